// File: rtl/mac512_operand_loader_if.sv
// Stream-in / operand-out bundle for the MAC operand loader.
// Optional MAC_LOADER_STATS_EN adds the pair_count statistics signal.
interface mac512_operand_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [255:0]      A_out;
    logic [255:0]      B_out;
    logic              op_valid;
    logic              op_take;
`ifdef MAC_LOADER_STATS_EN
    logic [15:0]       pair_count;

    modport master (
        output in_data, in_valid, op_take,
        input  in_ready, A_out, B_out, op_valid, pair_count
    );
    modport slave (
        input  in_data, in_valid, op_take,
        output in_ready, A_out, B_out, op_valid, pair_count
    );
`else
    modport master (
        output in_data, in_valid, op_take,
        input  in_ready, A_out, B_out, op_valid
    );
    modport slave (
        input  in_data, in_valid, op_take,
        output in_ready, A_out, B_out, op_valid
    );
`endif
endinterface

// File: rtl/mac512_operand_loader.sv
// Assembles 256-bit A/B operands from a narrow word stream into a shadow buffer and
// double-buffers them onto A_out/B_out. MAC_LOADER_STATS_EN enables the pair_count counter.
module mac512_operand_loader #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mac512_operand_loader_if.slave  bus
);
    localparam int N          = OP_W / WORD_W;
    localparam int PAIR_WORDS = 2 * N;
    localparam int CNT_W      = $clog2(PAIR_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAIR_WORDS - 1);

    if (OP_W != 256 || (OP_W % WORD_W) != 0) begin : g_bad_cfg
        $error("mac512_operand_loader: WORD_W must divide 256 and OP_W must be 256");
    end

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fill_state_t;

    fill_state_t       state_reg;
    logic [CNT_W-1:0]  word_cnt_reg;
    logic              op_valid_reg;
    logic [OP_W-1:0]   a_out_reg;
    logic [OP_W-1:0]   b_out_reg;
    logic [OP_W-1:0]   shadow_a;
    logic [OP_W-1:0]   shadow_b;
    logic              shadow_full;
    logic              accept;
    logic              transfer;

    assign shadow_full = (state_reg == HOLD);
    assign accept      = bus.in_valid && !shadow_full;
    assign transfer    = shadow_full && (!op_valid_reg || bus.op_take);

    // One register per shadow word; the word counter selects which one captures.
    for (genvar gi = 0; gi < N; gi++) begin : g_shadow
        logic [WORD_W-1:0] a_word_reg;
        logic [WORD_W-1:0] b_word_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_word_reg <= '0;
                b_word_reg <= '0;
            end else begin
                if (accept && word_cnt_reg == CNT_W'(gi)) begin
                    a_word_reg <= bus.in_data;
                end
                if (accept && word_cnt_reg == CNT_W'(gi + N)) begin
                    b_word_reg <= bus.in_data;
                end
            end
        end

        assign shadow_a[gi*WORD_W +: WORD_W] = a_word_reg;
        assign shadow_b[gi*WORD_W +: WORD_W] = b_word_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= FILL;
            word_cnt_reg <= '0;
            op_valid_reg <= 1'b0;
            a_out_reg    <= '0;
            b_out_reg    <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        if (word_cnt_reg == LAST_IDX) begin
                            word_cnt_reg <= '0;
                            state_reg    <= HOLD;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                        end
                    end
                    // Consumer drained the presented pair and nothing is waiting behind it.
                    if (bus.op_take && op_valid_reg) begin
                        op_valid_reg <= 1'b0;
                    end
                end
                HOLD: begin
                    if (transfer) begin
                        a_out_reg    <= shadow_a;
                        b_out_reg    <= shadow_b;
                        op_valid_reg <= 1'b1;
                        state_reg    <= FILL;
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    assign bus.in_ready = !shadow_full;
    assign bus.op_valid = op_valid_reg;
    assign bus.A_out    = a_out_reg;
    assign bus.B_out    = b_out_reg;

`ifdef MAC_LOADER_STATS_EN
    logic [15:0] pair_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_count_reg <= '0;
        end else if (transfer) begin
            pair_count_reg <= pair_count_reg + 16'd1;
        end
    end

    assign bus.pair_count = pair_count_reg;
`endif
endmodule

// File: tb/tb_mac512_operand_loader.sv
// Self-checking bench for mac512_operand_loader: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_mac512_operand_loader;
    localparam int WORD_W = 32;
    localparam int N      = 256 / WORD_W;
    localparam int PW     = 2 * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    mac512_operand_loader_if #(.WORD_W(WORD_W)) bus ();

    mac512_operand_loader #(.WORD_W(WORD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: words collected so far, pair-ready flag and the presented pair.
    logic [WORD_W-1:0] m_words[$];
    bit                m_full;
    bit                m_valid;
    logic [255:0]      m_a;
    logic [255:0]      m_b;
    int                m_pairs;

    task automatic model_reset();
        m_words.delete();
        m_full  = 1'b0;
        m_valid = 1'b0;
        m_a     = '0;
        m_b     = '0;
        m_pairs = 0;
    endtask

    function automatic logic [255:0] pack_words(input int first);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v = v | (256'(m_words[first + i]) << (i * WORD_W));
        end
        return v;
    endfunction

    task automatic model_edge(input bit iv, input logic [WORD_W-1:0] d, input bit take);
        bit ready;
        bit xfer;
        ready = !m_full;
        xfer  = m_full && (!m_valid || take);
        if (xfer) begin
            m_a = pack_words(0);
            m_b = pack_words(N);
            m_words.delete();
            m_full  = 1'b0;
            m_valid = 1'b1;
            m_pairs++;
            $display("[TB] pair %0d presented A[31:0]=%h B[31:0]=%h", m_pairs, m_a[31:0], m_b[31:0]);
        end else if (take && m_valid) begin
            m_valid = 1'b0;
        end
        if (iv && ready) begin
            m_words.push_back(d);
            if (m_words.size() == PW) m_full = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".in_ready"}, 256'(bus.in_ready), 256'(!m_full));
        check({tag, ".op_valid"}, 256'(bus.op_valid), 256'(m_valid));
        check({tag, ".A_out"}, bus.A_out, m_a);
        check({tag, ".B_out"}, bus.B_out, m_b);
`ifdef MAC_LOADER_STATS_EN
        check({tag, ".pair_count"}, 256'(bus.pair_count), 256'(m_pairs[15:0]));
`endif
    endtask

    task automatic step(input bit iv, input logic [WORD_W-1:0] d, input bit take, input string tag);
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.op_take  = take;
        model_edge(iv, d, take);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Offers nwords consecutive words, holding each until the loader accepts it.
    task automatic stream(input int nwords, input int base, input bit take_level, input string tag);
        int  sent;
        int  budget;
        bit  acc;
        sent   = 0;
        budget = 4 * nwords + 8;
        while (sent < nwords && budget > 0) begin
            acc = !m_full;
            step(1'b1, WORD_W'(base + sent), take_level, tag);
            if (acc) sent++;
            budget--;
        end
        bus.in_valid = 1'b0;
        bus.op_take  = 1'b0;
        tests++;
        if (sent < nwords) begin
            fails++;
            $display("FAIL %s.stream: got %0d words accepted expected %0d", tag, sent, nwords);
        end
    endtask

    // Asserts reset away from any clock edge and checks outputs respond without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op_take  = 1'b0;
        model_reset();
        #1;
        check({tag, ".rst_in_ready"}, 256'(bus.in_ready), 256'(1));
        check({tag, ".rst_op_valid"}, 256'(bus.op_valid), 256'(0));
        check({tag, ".rst_A_out"}, bus.A_out, 256'(0));
        check({tag, ".rst_B_out"}, bus.B_out, 256'(0));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        $display("[TB] %s: reset applied and released", tag);
    endtask

    typedef struct {
        bit                iv;
        logic [WORD_W-1:0] d;
        bit                take;
        bit                exp_ready;
        bit                exp_valid;
    } vec_t;

    vec_t         tbl[PW + 1];
    logic [255:0] exp_a;
    logic [255:0] exp_b;
    logic [255:0] held_a;
    logic [255:0] held_b;
    bit           pend;
    logic [WORD_W-1:0] pend_data;
    bit           acc;
    bit           tk;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.op_take  = 1'b0;
        model_reset();

        // Reset state straight from power-up, before any clock edge.
        #3;
        check("init.in_ready", 256'(bus.in_ready), 256'(1));
        check("init.op_valid", 256'(bus.op_valid), 256'(0));
        check("init.A_out", bus.A_out, 256'(0));
        check("init.B_out", bus.B_out, 256'(0));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Single pair 0x00..0x0F streamed back-to-back, then one idle edge for the transfer.
        for (int k = 0; k < PW; k++) begin
            tbl[k] = '{iv: 1'b1, d: WORD_W'(k), take: 1'b0,
                       exp_ready: (k != PW - 1), exp_valid: 1'b0};
        end
        tbl[PW] = '{iv: 1'b0, d: '0, take: 1'b0, exp_ready: 1'b1, exp_valid: 1'b1};
        for (int r = 0; r <= PW; r++) begin
            step(tbl[r].iv, tbl[r].d, tbl[r].take, "table");
            check($sformatf("table[%0d].in_ready", r), 256'(bus.in_ready), 256'(tbl[r].exp_ready));
            check($sformatf("table[%0d].op_valid", r), 256'(bus.op_valid), 256'(tbl[r].exp_valid));
            $display("[TB] table row %0d: in_valid=%0b data=%h in_ready=%0b op_valid=%0b",
                     r, tbl[r].iv, tbl[r].d, bus.in_ready, bus.op_valid);
        end
        check("single.A_lo", 256'(bus.A_out[31:0]), 256'(32'h0));
        check("single.A_hi", 256'(bus.A_out[255:224]), 256'(32'h7));
        check("single.B_lo", 256'(bus.B_out[31:0]), 256'(32'h8));
        check("single.B_hi", 256'(bus.B_out[255:224]), 256'(32'hF));

        // Reset mid-fill after 5 words, then a fresh pair must carry no residue.
        stream(5, 'h200, 1'b0, "abort");
        async_reset("abort");
        stream(PW, 'h100, 1'b0, "fresh");
        step(1'b0, '0, 1'b0, "fresh");
        exp_a = '0;
        exp_b = '0;
        for (int k = 0; k < N; k++) begin
            exp_a[k*WORD_W +: WORD_W] = WORD_W'('h100 + k);
            exp_b[k*WORD_W +: WORD_W] = WORD_W'('h100 + N + k);
        end
        check("fresh.op_valid", 256'(bus.op_valid), 256'(1));
        check("fresh.A_out", bus.A_out, exp_a);
        check("fresh.B_out", bus.B_out, exp_b);

        // Backpressure: 32 words without op_take, then word 33 held while the shadow is full.
        async_reset("bp");
        stream(2 * PW, 'h300, 1'b0, "bp");
        check("bp.in_ready_full", 256'(bus.in_ready), 256'(0));
        check("bp.first_A_lo", 256'(bus.A_out[31:0]), 256'(32'h300));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, WORD_W'('h320), 1'b0, "bp_hold");
            check("bp_hold.in_ready", 256'(bus.in_ready), 256'(0));
            check("bp_hold.A_lo", 256'(bus.A_out[31:0]), 256'(32'h300));
        end
        step(1'b1, WORD_W'('h320), 1'b1, "bp_take");
        check("bp_take.op_valid", 256'(bus.op_valid), 256'(1));
        check("bp_take.A_lo", 256'(bus.A_out[31:0]), 256'(32'h310));
        check("bp_take.B_hi", 256'(bus.B_out[255:224]), 256'(32'h31F));
        check("bp_take.in_ready", 256'(bus.in_ready), 256'(1));
        step(1'b1, WORD_W'('h320), 1'b0, "bp_word33");

        // op_take with an empty shadow drops op_valid; a second op_take changes nothing.
        held_a = exp_a;
        held_b = exp_b;
        for (int k = 0; k < N; k++) begin
            held_a[k*WORD_W +: WORD_W] = WORD_W'('h310 + k);
            held_b[k*WORD_W +: WORD_W] = WORD_W'('h310 + N + k);
        end
        step(1'b0, '0, 1'b1, "drain");
        check("drain.op_valid", 256'(bus.op_valid), 256'(0));
        check("drain.A_out", bus.A_out, held_a);
        check("drain.B_out", bus.B_out, held_b);
        step(1'b0, '0, 1'b1, "drain2");
        check("drain2.op_valid", 256'(bus.op_valid), 256'(0));
        check("drain2.A_out", bus.A_out, held_a);

        // Three pairs delivered with a consumer that takes continuously.
        async_reset("stats");
        stream(3 * PW, 'h400, 1'b1, "stats");
        step(1'b0, '0, 1'b0, "stats_tail");
`ifdef MAC_LOADER_STATS_EN
        check("stats.pair_count", 256'(bus.pair_count), 256'(16'd3));
`endif
        check("stats.A_lo", 256'(bus.A_out[31:0]), 256'(32'h420));

        // Randomized traffic obeying the valid/ready hold rule.
        async_reset("rand");
        pend      = 1'b0;
        pend_data = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend      = 1'b1;
                pend_data = WORD_W'($urandom);
            end
            tk  = ($urandom_range(0, 9) < 3);
            acc = pend && !m_full;
            step(pend, pend_data, tk, "rand");
            if (acc) pend = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mac512_operand_loader.md
# mac512_operand_loader

Upstream feeder for the 512-bit shift-add MAC. It assembles 256-bit A and B operands from a narrow valid/ready word stream and double-buffers them. A complete pair is held stable on `A_out`/`B_out` until the MAC stage signals that it has latched it. One stream interface therefore keeps the MAC supplied with back-to-back operand pairs.

## Interface
Parameters:
- `WORD_W`, 32, input word width; must divide 256 exactly (legal: 8, 16, 32, 64, 128, 256).
- `OP_W`, 256, operand width; fixed, not to be overridden.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WORD_W  operand word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `A_out`  out  256  presented operand A.
- `B_out`  out  256  presented operand B.
- `op_valid`  out  1  `A_out`/`B_out` hold a complete, unconsumed pair.
- `op_take`  in  1  one-cycle pulse from the MAC side: the presented pair has been latched.
- `pair_count`  out  16  pairs delivered to the presented buffer; present only with `MAC_LOADER_STATS_EN`.

## Operation
- N = 256/WORD_W words per operand; 2N words per pair.
- A word is accepted on a rising edge with `in_valid && in_ready`.
- Word order is A first, then B, least-significant word first.
  - Accepted word k (0 ≤ k < N) goes to shadow A[k*WORD_W +: WORD_W].
  - Accepted word k (N ≤ k < 2N) goes to shadow B[(k-N)*WORD_W +: WORD_W].
- Word index counter: width clog2(2N), reset 0. Wraps to 0 after word 2N-1 is accepted; at the same edge `shadow_full` is set.
- Fill FSM states:
  - FILL: `shadow_full`=0, `in_ready`=1.
  - HOLD: `shadow_full`=1, `in_ready`=0.
  - FILL→HOLD on acceptance of word 2N-1.
  - HOLD→FILL on transfer.
- `in_ready` = !`shadow_full`, decoded from the register (no combinational path from `in_valid` or `op_take`).
- Transfer (shadow → presented, `op_valid`←1, `shadow_full`←0) occurs on an edge where `shadow_full` && (!`op_valid` || `op_take`).
- `op_take` && `op_valid` && !`shadow_full`: `op_valid`←0. `A_out`/`B_out` keep their last values.
- `op_take` while `op_valid`=0: ignored, no state change.
- `op_take` and transfer on the same edge: new pair presented and `op_valid` stays 1, with no bubble.
- `A_out`/`B_out` change only on a transfer edge or on reset.
- Reset mid-fill: partial words are discarded, counter returns to 0, and the shadow is cleared.

## Timing
- Reset values: `in_ready`=1, `op_valid`=0, `A_out`=0, `B_out`=0, `pair_count`=0, counter=0, shadow=0, FSM=FILL.
- Last word accepted at edge E, presented buffer empty:
  - `shadow_full`=1 after E.
  - Transfer at E+1; `op_valid`=1 after E+1.
  - `in_ready` low only during the cycle between E and E+1.
- Fill latency at full rate: 2N accepting edges plus 1 transfer edge per pair. Pair throughput is one per 2N+1 cycles when the consumer takes immediately.
- Backpressure: while in HOLD, `in_data` is not sampled and the stream must hold its word (valid/ready rule: the source must not drop `in_valid` once asserted without a handshake).
- `op_take` sampled only on rising edges; a level held high consumes one pair per cycle.

## Configuration
- `MAC_LOADER_STATS_EN` defined:
  - `pair_count` port exists; resets to 0.
  - Increments by 1 on every transfer edge, wraps at 16 bits.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle. Required: `in_ready`=1, `op_valid`=0, `A_out`=`B_out`=0 immediately (asynchronous), with no clock needed.
- Single pair, WORD_W=32, words 0x00..0x0F streamed back-to-back.
  - Required: `op_valid` rises 1 cycle after word 0x0F.
  - `A_out`[31:0]=0x0, `A_out`[255:224]=0x7, `B_out`[31:0]=0x8, `B_out`[255:224]=0xF.
- Backpressure: stream 32 words with no `op_take`.
  - Required: first pair presented; second pair fills the shadow, then `in_ready`=0 and word 33 is held.
  - `op_take` pulse → second pair presented at that edge, `op_valid` stays 1, `in_ready`=1 next cycle.
- `op_take` with empty shadow: required `op_valid`→0 next cycle, `A_out`/`B_out` unchanged. A further `op_take` is ignored.
- Reset mid-fill after 5 words, then stream a full fresh pair. Required: the presented pair contains only the fresh 16 words; no residue from the aborted fill.
- With `MAC_LOADER_STATS_EN`, deliver 3 pairs. Required: `pair_count`=3. Without the macro, the build elaborates with no `pair_count` port.
